// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//   Modulo-MODULUS up/down counter. It supports a parallel load with clamping,
//   and it can either wrap or saturate at the count limits. It also keeps a
//   running count of wraps.
//
// Parameters
//   WIDTH    : counter register width in bits
//   MODULUS  : count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
// Ports
//   clk      : single clock, all state changes on its rising edge
//   rst      : synchronous, active-high reset
//   en       : count enable
//   load     : parallel load strobe (takes priority over en)
//   d        : parallel load value (clamped to MODULUS-1)
//   up       : direction, 1 = increment, 0 = decrement
//   sat_mode : limit behaviour, 1 = saturate, 0 = wrap
//   q        : registered count value
//   tc       : registered one-cycle pulse after each wrap
//   at_limit : combinational, q sits at the limit for the current direction
//   wrap_cnt : registered number of wraps since reset (modulo 256)
// -----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_limit,
  output logic [7:0]       wrap_cnt
);

  // MODULUS may equal 2**WIDTH, so a one-bit-wider copy is kept for the clamp
  // compare. The top count value does always fit in WIDTH bits.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_Q  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic [7:0]       wrap_cnt_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic             tc_nxt_s;
  logic [7:0]       wrap_cnt_nxt_s;

  // Out-of-range load values are clamped to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if ({1'b0, v} < MOD_EXT) begin
      r = v;
    end else begin
      r = MAX_Q;
    end
    return r;
  endfunction

  // Next-state selection: load beats enable, and no operation means hold.
  always_comb begin
    q_nxt_s        = q_r;
    tc_nxt_s       = 1'b0;
    wrap_cnt_nxt_s = wrap_cnt_r;
    case ({load, en})
      2'b10, 2'b11: begin
        q_nxt_s = clamp_load(d);
      end
      2'b01: begin
        if (up) begin
          // ">=" keeps any out-of-range state on the limit path.
          if (q_r >= MAX_Q) begin
            if (sat_mode) begin
              q_nxt_s = MAX_Q;
            end else begin
              q_nxt_s        = ZERO_Q;
              tc_nxt_s       = 1'b1;
              wrap_cnt_nxt_s = wrap_cnt_r + 8'd1;
            end
          end else begin
            q_nxt_s = q_r + ONE_Q;
          end
        end else begin
          if (q_r == ZERO_Q) begin
            if (sat_mode) begin
              q_nxt_s = ZERO_Q;
            end else begin
              q_nxt_s        = MAX_Q;
              tc_nxt_s       = 1'b1;
              wrap_cnt_nxt_s = wrap_cnt_r + 8'd1;
            end
          end else begin
            q_nxt_s = q_r - ONE_Q;
          end
        end
      end
      default: begin
        q_nxt_s = q_r;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r        <= ZERO_Q;
      tc_r       <= 1'b0;
      wrap_cnt_r <= 8'd0;
    end else begin
      q_r        <= q_nxt_s;
      tc_r       <= tc_nxt_s;
      wrap_cnt_r <= wrap_cnt_nxt_s;
    end
  end

  assign q        = q_r;
  assign tc       = tc_r;
  assign wrap_cnt = wrap_cnt_r;
  assign at_limit = up ? (q_r == MAX_Q) : (q_r == ZERO_Q);

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, counter register width in bits.
REQ-002 SHALL provide parameter MODULUS, default 200, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL provide port en  input  1  count enable; active-high.
REQ-006 SHALL provide port load  input  1  parallel load strobe; active-high.
REQ-007 SHALL provide port d  input  WIDTH  parallel load value.
REQ-008 SHALL provide port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-009 SHALL provide port sat_mode  input  1  limit behaviour; 1 = saturate, 0 = wrap.
REQ-010 SHALL provide port q  output  WIDTH  registered count value.
REQ-011 SHALL provide port tc  output  1  registered terminal-count pulse; high for one cycle after each wrap.
REQ-012 SHALL provide port at_limit  output  1  combinational; high when q equals the limit for the current direction.
REQ-013 SHALL provide port wrap_cnt  output  8  registered count of wraps since reset; rolls over 255 -> 0.

Function
REQ-014 SHALL apply per-edge priority: rst > load > en > hold.
REQ-015 SHALL, on load, set q to d if d < MODULUS, else to MODULUS-1 (clamp); tc goes 0 that cycle regardless of en/up.
REQ-016 SHALL, with en=1, up=1, q < MODULUS-1, set q to q+1 and tc to 0.
REQ-017 SHALL, with en=1, up=0, q > 0, set q to q-1 and tc to 0.
REQ-018 SHALL, with en=1, up=1, q = MODULUS-1, sat_mode=0, set q to 0, tc to 1 and wrap_cnt to wrap_cnt+1.
REQ-019 SHALL, with en=1, up=0, q = 0, sat_mode=0, set q to MODULUS-1, tc to 1 and wrap_cnt to wrap_cnt+1.
REQ-020 SHALL, with en=1 at the limit and sat_mode=1, hold q with tc 0 and wrap_cnt unchanged.
REQ-021 SHALL, with en=0 and load=0, hold q and wrap_cnt and drive tc to 0.
REQ-022 SHALL drive at_limit = (up ? q == MODULUS-1 : q == 0), independent of en and sat_mode.
REQ-023 SHALL sample up and sat_mode each cycle; direction or mode change takes effect on the same edge, with no pipeline delay.
REQ-024 SHALL perform all arithmetic modulo MODULUS only, never modulo 2**WIDTH; q SHALL never exceed MODULUS-1.
REQ-025 SHALL tolerate MODULUS = 2**WIDTH; then wrap occurs at all-ones -> 0 with identical tc/wrap_cnt behaviour.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, set q=0, tc=0, wrap_cnt=0, regardless of load, en and d.
REQ-027 SHALL, on reset mid-count or mid-load, discard the pending operation; counting resumes from 0 on the first edge with rst=0.
REQ-028 SHALL leave at_limit valid during reset: 1 if up=0, 0 if up=1 (MODULUS > 1).

Verification
REQ-029 Up wrap: rst, load d=198, en=1 up=1 sat_mode=0 for 3 edges -> q 199, 0, 1; tc=1 only in cycle q=0; wrap_cnt=1.
REQ-030 Down saturate: load d=2, en=1 up=0 sat_mode=1 for 4 edges -> q 1, 0, 0, 0; tc never 1; at_limit=1 from q=0.
REQ-031 Load clamp and priority: load=1 d=250 en=1 -> q=199, tc=0; then rst=1 with load=1 d=5 -> q=0, wrap_cnt=0.
REQ-032 Down wrap: q=0, en=1 up=0 sat_mode=0, one edge -> q=199, tc=1, wrap_cnt increments by 1.
REQ-033 Enable gap: count to q=10, en=0 for 5 edges -> q stays 10, tc=0; en=1 -> q=11.
REQ-034 wrap_cnt rollover: 256 up wraps after reset -> wrap_cnt reads 0; parameter sweep WIDTH=3, MODULUS=8 repeats REQ-029 with 6 -> 7, 0, 1.
